program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width, so depth = 2^ADDR_W words.
REQ-002 clk  in  1  rising-edge clock, single clock domain.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 load_en  in  1  level; a rising edge sampled on clk starts a load session.
REQ-005 byte_valid  in  1  source has a byte on byte_data.
REQ-006 byte_data  in  8  serial program byte.
REQ-007 byte_ready  out  1  loader accepts a byte this cycle.
REQ-008 mem_we  out  1  instruction-memory write strobe, one cycle per word.
REQ-009 mem_addr  out  ADDR_W  instruction-memory word address.
REQ-010 mem_wdata  out  32  instruction word to write.
REQ-011 start  out  1  one-cycle pulse that releases the processor after a good load.
REQ-012 busy  out  1  a session is in progress.
REQ-013 done  out  1  sticky flag: last session completed without error.
REQ-014 err  out  1  sticky flag: last session was rejected.

Function
REQ-015 A byte transfers only on a clk edge where byte_valid=1 and byte_ready=1; byte_data is ignored otherwise.
REQ-016 FSM states: IDLE, HDR0, HDR1, DATA, WRITE, FIN, ERR.
REQ-017 IDLE: a load_en rising edge clears done/err, zeroes the word counter and byte index, and moves to HDR0 on the next cycle. IDLE ignores byte_valid.
REQ-018 HDR0 accepts the low byte of the 16-bit word count N. HDR1 accepts the high byte of N.
REQ-019 After HDR1: if N=0 or N>2^ADDR_W, go to ERR. Otherwise go to DATA.
REQ-020 DATA assembles words little-endian. Bytes 0 to 3 of a word go to bits [7:0], [15:8], [23:16] and [31:24].
REQ-021 After the 4th accepted byte of a word, go to WRITE. WRITE lasts exactly one cycle with mem_we=1, mem_addr = word index and mem_wdata = the assembled word.
REQ-022 From WRITE: if word index = N-1, go to FIN. Otherwise increment the word index and return to DATA.
REQ-023 Write latency: mem_we is asserted in the cycle immediately after the cycle in which the 4th byte is accepted.
REQ-024 byte_ready=1 only in HDR0, HDR1 and DATA. It is 0 in IDLE, WRITE, FIN and ERR, so back-to-back source bytes stall one cycle per word.
REQ-025 FIN lasts one cycle with start=1, sets done=1, then goes to IDLE.
REQ-026 ERR lasts one cycle, sets err=1, then goes to IDLE. No memory write and no start pulse occur in a rejected session.
REQ-027 busy=1 in every state except IDLE.
REQ-028 A load_en edge while busy=1 is ignored.
REQ-029 Dropping load_en mid-session does not abort the session.
REQ-030 For N = 2^ADDR_W, the last write uses mem_addr = all-ones. The address never wraps within a session.
REQ-031 mem_addr and mem_wdata hold their last values outside WRITE. Only mem_we qualifies them.
REQ-032 start and mem_we are never asserted in the same cycle.

Reset
REQ-033 rst=0 immediately forces: state IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, start=0, busy=0, done=0, err=0, counters 0.
REQ-034 A reset mid-session abandons the session without a write or start. Words already written stay in memory.
REQ-035 After rst deasserts, a fresh load_en rising edge is required to begin a session. A load_en held high through reset does not start one.

Verification
REQ-036 N=1, bytes 01 00 78 56 34 12 streamed with byte_valid held high -> one mem_we at addr 0 with data 0x12345678, then start=1 for one cycle, done=1, busy=0.
REQ-037 N=3, continuous stream -> writes at addr 0, 1, 2 in order. byte_ready=0 during each WRITE cycle. Exactly 12 data bytes are consumed. Exactly one start pulse.
REQ-038 N=0 (header 00 00) -> err=1, no mem_we, no start. A following valid session clears err and sets done.
REQ-039 ADDR_W=8 with N=257 (header 01 01) -> err=1 with no write. With N=256 -> the last write is at addr 0xFF and done=1.
REQ-040 rst pulsed low after 2 words of an N=4 load -> all outputs 0 asynchronously. No further writes. No start pulse after release until a new load_en edge.
REQ-041 byte_valid toggled randomly, and load_en re-pulsed mid-session -> memory contents and word order are identical to the continuous case, and the session is not restarted.

Source files
------------

// File: rtl/program_loader.sv
// program_loader
//   Receives a program image as a byte stream and writes it into an
//   instruction memory one 32-bit word at a time. Once the whole image
//   has been written, it pulses start to release the processor.
//
//   Image format: 16-bit word count N (low byte first), followed by
//   N little-endian 32-bit words. A session whose N is 0 or larger than
//   the memory depth (2^ADDR_W words) is rejected: nothing is written
//   and no start pulse is produced.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   load_en     a rising edge while idle starts a session
//   byte_valid  source presents byte_data
//   byte_data   program byte
//   byte_ready  loader accepts a byte this cycle (valid & ready = transfer)
//   mem_we      instruction-memory write strobe, one cycle per word
//   mem_addr    instruction-memory word address (held between writes)
//   mem_wdata   instruction word (held between writes)
//   start       one-cycle pulse after a successful load
//   busy        a session is in progress
//   done        sticky: the last session completed
//   err         sticky: the last session was rejected
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Memory depth as a 17-bit value so that 2^16 is representable.
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_WRITE,
    S_FIN,
    S_ERR
  } state_t;

  state_t state;
  state_t state_nx;

  logic              load_q;     // load_en delayed one cycle, for edge detection
  logic              load_rise;
  logic              accept;     // a byte transfers on this edge
  logic [15:0]       word_cnt;   // N from the header
  logic [ADDR_W-1:0] word_idx;   // index of the word being assembled
  logic [1:0]        byte_idx;   // byte position within the current word
  logic [23:0]       asm_q;      // bytes 0..2 of the current word
  logic [15:0]       n_hdr;      // N as it completes in HDR1
  logic              n_bad;
  logic              last_word;

  assign load_rise = load_en & ~load_q;
  assign accept    = byte_valid & byte_ready;

  // The high header byte is on byte_data when N is judged, so the check
  // uses it directly rather than waiting for word_cnt to be updated.
  assign n_hdr = {byte_data, word_cnt[7:0]};
  assign n_bad = (n_hdr == 16'd0) || ({1'b0, n_hdr} > MAX_WORDS);

  assign last_word = (17'(word_idx) == (17'(word_cnt) - 17'd1));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (load_rise) begin
          state_nx = S_HDR0;
        end
      end
      S_HDR0: begin
        if (accept) begin
          state_nx = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          state_nx = n_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (accept && (byte_idx == 2'd3)) begin
          state_nx = S_WRITE;
        end
      end
      S_WRITE: begin
        state_nx = last_word ? S_FIN : S_DATA;
      end
      S_FIN: begin
        state_nx = S_IDLE;
      end
      S_ERR: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Output decode (Moore)
  // ---------------------------------------------------------------------
  always_comb begin
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    start      = 1'b0;
    busy       = 1'b1;
    case (state)
      S_IDLE:  busy       = 1'b0;
      S_HDR0:  byte_ready = 1'b1;
      S_HDR1:  byte_ready = 1'b1;
      S_DATA:  byte_ready = 1'b1;
      S_WRITE: mem_we     = 1'b1;
      S_FIN:   start      = 1'b1;
      default: begin
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: header capture, word assembly, flags
  // ---------------------------------------------------------------------
  // load_q resets high: a load_en held high through reset must not be
  // seen as a rising edge once reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      load_q    <= 1'b1;
      word_cnt  <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      asm_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      load_q <= load_en;
      case (state)
        S_IDLE: begin
          if (load_rise) begin
            done     <= 1'b0;
            err      <= 1'b0;
            word_cnt <= '0;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        S_HDR0: begin
          if (accept) begin
            word_cnt[7:0] <= byte_data;
          end
        end
        S_HDR1: begin
          if (accept) begin
            word_cnt[15:8] <= byte_data;
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            // The 4th byte goes straight into the write register together
            // with the three staged bytes, so mem_wdata and mem_addr only
            // change on entry to WRITE and hold otherwise.
            case (byte_idx)
              2'd0: asm_q[7:0]   <= byte_data;
              2'd1: asm_q[15:8]  <= byte_data;
              2'd2: asm_q[23:16] <= byte_data;
              2'd3: begin
                mem_wdata <= {byte_data, asm_q};
                mem_addr  <= word_idx;
              end
            endcase
          end
        end
        S_WRITE: begin
          // Not incremented after the last word, so N = depth never wraps.
          if (!last_word) begin
            word_idx <= word_idx + 1'b1;
          end
        end
        S_FIN: begin
          done <= 1'b1;
        end
        S_ERR: begin
          err <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
`timescale 1ns/1ps
module tb_program_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              load_en = 1'b0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Stimulus image and observed memory.
  logic [31:0] tx_words[DEPTH];
  logic [31:0] got_mem[DEPTH];
  logic [31:0] ref_mem[DEPTH];
  logic [7:0]  src_q[$];

  // Behavioural model: parses the accepted byte stream as header + words.
  bit          m_active = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_n = '0;
  logic [31:0] m_word = '0;
  int          m_words_done = 0;
  bit          pend_w = 1'b0, pend_s = 1'b0, pend_e = 1'b0;
  bit          post_s = 1'b0, post_e = 1'b0;
  bit          sess_end = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [31:0]       exp_data = '0;

  int                we_cnt = 0;
  int                start_cnt = 0;
  logic [ADDR_W-1:0] last_addr = '0;
  logic [31:0]       last_data = '0;

  always @(negedge clk) begin
    logic       acc;
    logic [7:0] b;
    int         di;
    bit         n_s;
    if (!rst) begin
      chk("reset_flags", 32'({byte_ready, mem_we, start, busy, done, err}), 32'd0);
      chk("reset_addr", 32'(mem_addr), 32'd0);
      chk("reset_wdata", mem_wdata, 32'd0);
      m_active = 1'b0;
      pend_w = 1'b0; pend_s = 1'b0; pend_e = 1'b0;
      post_s = 1'b0; post_e = 1'b0;
    end else begin
      acc = byte_valid && byte_ready;
      if (mem_we) begin
        we_cnt++;
        got_mem[mem_addr] = mem_wdata;
        last_addr = mem_addr;
        last_data = mem_wdata;
      end
      if (start) start_cnt++;

      chk("mem_we", 32'(mem_we), 32'(pend_w));
      if (pend_w) begin
        chk("write_addr", 32'(mem_addr), 32'(exp_addr));
        chk("write_data", mem_wdata, exp_data);
        chk("ready_in_write", 32'(byte_ready), 32'd0);
      end
      chk("start", 32'(start), 32'(pend_s));
      if (pend_s) chk("fin_ready_busy", 32'({byte_ready, busy}), 32'b01);
      if (pend_e) chk("errstate_ready_busy", 32'({byte_ready, busy}), 32'b01);
      if (post_s) chk("after_fin_done_err_busy", 32'({done, err, busy}), 32'b100);
      if (post_e) chk("after_err_done_err_busy", 32'({done, err, busy}), 32'b010);
      if (!m_active) chk("ready_when_idle", 32'(byte_ready), 32'd0);
      else if (m_cnt > 0) chk("busy_in_session", 32'(busy), 32'd1);

      post_s = pend_s;
      post_e = pend_e;
      if (pend_s || pend_e) begin
        m_active = 1'b0;
        sess_end = 1'b1;
      end
      n_s = 1'b0;
      if (pend_w) begin
        ref_mem[exp_addr] = exp_data;
        m_words_done++;
        if (m_words_done == int'(m_n)) n_s = 1'b1;
      end
      pend_s = n_s;
      pend_e = 1'b0;
      pend_w = 1'b0;

      if (acc) begin
        chk("accept_in_session", 32'(m_active && (src_q.size() > 0)), 32'd1);
        if (m_active && src_q.size() > 0) begin
          b = src_q.pop_front();
          m_cnt++;
          if (m_cnt == 1) begin
            m_n[7:0] = b;
          end else if (m_cnt == 2) begin
            m_n[15:8] = b;
            if (m_n == 16'd0 || int'(m_n) > DEPTH) pend_e = 1'b1;
          end else begin
            di = (m_cnt - 3) % 4;
            m_word[8*di +: 8] = b;
            if (di == 3) begin
              pend_w   = 1'b1;
              exp_addr = ADDR_W'((m_cnt - 3) / 4);
              exp_data = m_word;
              m_word   = '0;
            end
          end
        end
      end
    end
  end

  // Runs one session: header n_hdr, nwords words from tx_words, then junk
  // bytes that must never be consumed. abort_w > 0 stops driving after that
  // many writes so the caller can intervene.
  task automatic run_session(input logic [15:0] n_hdr, input int nwords, input int vpct,
                             input bit repulse, input int junk, input int abort_w);
    int cyc;
    @(posedge clk); #1;
    load_en = 1'b0;
    byte_valid = 1'b0;
    @(posedge clk); #1;
    src_q.delete();
    src_q.push_back(n_hdr[7:0]);
    src_q.push_back(n_hdr[15:8]);
    for (int w = 0; w < nwords; w++) begin
      for (int k = 0; k < 4; k++) src_q.push_back(tx_words[w][8*k +: 8]);
    end
    for (int j = 0; j < junk; j++) src_q.push_back(8'($urandom));
    m_active = 1'b1; m_cnt = 0; m_n = '0; m_word = '0; m_words_done = 0;
    sess_end = 1'b0; we_cnt = 0; start_cnt = 0;
    load_en = 1'b1;
    cyc = 0;
    while (!sess_end && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
      if (sess_end) break;
      if (abort_w > 0 && we_cnt >= abort_w) break;
      byte_valid = (src_q.size() > 0) && ($urandom_range(99) < vpct);
      if (byte_valid) byte_data = src_q[0];
      else byte_data = 8'($urandom);
      if (repulse) load_en = 1'($urandom_range(1));
    end
    if (abort_w == 0) begin
      chk("session_completes", 32'(sess_end), 32'd1);
      @(posedge clk); #1;
      byte_valid = 1'b0;
      chk("junk_not_consumed", 32'(src_q.size()), 32'(junk));
      chk("busy_after_session", 32'(busy), 32'd0);
    end else begin
      chk("writes_before_abort", 32'(we_cnt), 32'(abort_w));
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) begin
      got_mem[i] = 32'hDEAD_BEEF;
      ref_mem[i] = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    clear_mem();
    // Reset with load_en held high: no session may start on release.
    load_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("held_load_en_no_session", 32'({busy, done, err, start}), 32'd0);

    // N=1, single word 0x12345678, continuous stream.
    tx_words[0] = 32'h1234_5678;
    run_session(16'd1, 1, 100, 1'b0, 3, 0);
    chk("n1_write_count", 32'(we_cnt), 32'd1);
    chk("n1_addr", 32'(last_addr), 32'h0);
    chk("n1_data", last_data, 32'h1234_5678);
    chk("n1_start_count", 32'(start_cnt), 32'd1);
    chk("n1_flags", 32'({done, err, busy}), 32'b100);

    // N=3, continuous: three ordered writes, 12 data bytes, one start.
    clear_mem();
    for (int i = 0; i < 3; i++) tx_words[i] = $urandom;
    run_session(16'd3, 3, 100, 1'b0, 4, 0);
    chk("n3_write_count", 32'(we_cnt), 32'd3);
    chk("n3_start_count", 32'(start_cnt), 32'd1);
    for (int i = 0; i < 3; i++) chk("n3_mem", got_mem[i], tx_words[i]);

    // N=0 rejected, then a valid session clears err.
    run_session(16'd0, 0, 100, 1'b0, 8, 0);
    chk("n0_flags", 32'({done, err}), 32'b01);
    chk("n0_no_write", 32'(we_cnt), 32'd0);
    chk("n0_no_start", 32'(start_cnt), 32'd0);
    for (int i = 0; i < 2; i++) tx_words[i] = $urandom;
    run_session(16'd2, 2, 60, 1'b0, 0, 0);
    chk("after_err_flags", 32'({done, err}), 32'b10);

    // N=257 exceeds depth; N=256 fills it exactly.
    run_session(16'd257, 0, 100, 1'b0, 8, 0);
    chk("n257_flags", 32'({done, err}), 32'b01);
    chk("n257_no_write", 32'(we_cnt), 32'd0);
    clear_mem();
    for (int i = 0; i < DEPTH; i++) tx_words[i] = $urandom;
    run_session(16'd256, 256, 100, 1'b0, 0, 0);
    chk("n256_write_count", 32'(we_cnt), 32'd256);
    chk("n256_last_addr", 32'(last_addr), 32'hFF);
    chk("n256_done", 32'({done, err}), 32'b10);
    for (int i = 0; i < DEPTH; i++) chk("n256_mem", got_mem[i], tx_words[i]);

    // Continuous vs throttled with load_en re-pulsed: same memory image.
    clear_mem();
    for (int i = 0; i < 6; i++) tx_words[i] = $urandom;
    run_session(16'd6, 6, 100, 1'b0, 0, 0);
    for (int i = 0; i < 6; i++) chk("cont_mem", got_mem[i], tx_words[i]);
    clear_mem();
    run_session(16'd6, 6, 40, 1'b1, 0, 0);
    chk("throttled_write_count", 32'(we_cnt), 32'd6);
    chk("throttled_start_count", 32'(start_cnt), 32'd1);
    for (int i = 0; i < 6; i++) chk("throttled_mem", got_mem[i], tx_words[i]);
    for (int i = 0; i < 6; i++) chk("ref_mem", ref_mem[i], tx_words[i]);

    // Reset after two words of an N=4 load.
    for (int i = 0; i < 4; i++) tx_words[i] = $urandom | 32'h1;
    run_session(16'd4, 4, 100, 1'b0, 0, 2);
    @(posedge clk); #3;
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_flags", 32'({byte_ready, mem_we, start, busy, done, err}), 32'd0);
    chk("async_reset_addr", 32'(mem_addr), 32'd0);
    chk("async_reset_wdata", mem_wdata, 32'd0);
    load_en = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      byte_valid = 1'($urandom_range(1));
      byte_data  = 8'($urandom);
    end
    byte_valid = 1'b0;
    chk("abort_write_count", 32'(we_cnt), 32'd2);
    chk("abort_no_start", 32'(start_cnt), 32'd0);
    chk("abort_idle", 32'({busy, done, err}), 32'd0);

    // A fresh edge works after the aborted session.
    run_session(16'd4, 4, 80, 1'b0, 0, 0);
    chk("post_abort_writes", 32'(we_cnt), 32'd4);
    chk("post_abort_done", 32'({done, err}), 32'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
